// File: rtl/escalonador_chamadas_pkg.sv
// Shared definitions for the elevator call scheduler.
//   N_ANDARES_DEF / W_ANDAR_DEF : default floor count and floor-index width
//   estado_t                    : scheduler FSM state encoding
package pacote_elevador;

  localparam int N_ANDARES_DEF = 4;
  localparam int W_ANDAR_DEF   = 2;

  typedef enum logic [1:0] {
    PARADO       = 2'b00,
    MOVENDO      = 2'b01,
    PORTA_ABERTA = 2'b10
  } estado_t;

endpackage

// File: rtl/escalonador_chamadas_seletor_alvo.sv
// Combinational target search over the latched calls.
//   pendentes        : latched calls, bit i = floor i
//   andar            : reference floor (the car's current floor)
//   subindo          : current travel direction (1 = up)
//   tem_acima/abaixo : a call exists strictly above/below andar
//   mais_prox_*      : nearest such call (andar when none exists)
//   alvo, subir      : SCAN choice (target floor and resulting direction)
module seletor_alvo
  import pacote_elevador::*;
#(
  parameter int N_ANDARES = N_ANDARES_DEF,
  parameter int W_ANDAR   = W_ANDAR_DEF
) (
  input  logic [N_ANDARES-1:0] pendentes,
  input  logic [W_ANDAR-1:0]   andar,
  input  logic                 subindo,
  output logic                 tem_acima,
  output logic                 tem_abaixo,
  output logic [W_ANDAR-1:0]   mais_prox_acima,
  output logic [W_ANDAR-1:0]   mais_prox_abaixo,
  output logic [W_ANDAR-1:0]   alvo,
  output logic                 subir
);

  // Scanning away from the car and keeping the last hit leaves the nearest call.
  always_comb begin
    tem_acima        = 1'b0;
    tem_abaixo       = 1'b0;
    mais_prox_acima  = andar;
    mais_prox_abaixo = andar;
    for (int i = N_ANDARES - 1; i >= 0; i--) begin
      if (pendentes[i] && (W_ANDAR'(i) > andar)) begin
        tem_acima       = 1'b1;
        mais_prox_acima = W_ANDAR'(i);
      end
    end
    for (int i = 0; i < N_ANDARES; i++) begin
      if (pendentes[i] && (W_ANDAR'(i) < andar)) begin
        tem_abaixo       = 1'b1;
        mais_prox_abaixo = W_ANDAR'(i);
      end
    end
  end

  // SCAN: keep going up while calls remain above, otherwise serve below,
  // and only fall back to going up when nothing is below.
  always_comb begin
    alvo  = mais_prox_acima;
    subir = 1'b1;
    if (subindo && tem_acima) begin
      alvo  = mais_prox_acima;
      subir = 1'b1;
    end else if (tem_abaixo) begin
      alvo  = mais_prox_abaixo;
      subir = 1'b0;
    end
  end

endmodule

// File: rtl/escalonador_chamadas.sv
// Elevator call scheduler: latches call buttons, picks the next stop with a
// SCAN policy, drives the floor controller and times the door-open phase.
//   clock_in      : system clock, rising edge
//   reset         : synchronous active-high reset (homes the car to floor 0)
//   botoes        : call buttons, bit i = floor i
//   andar_atual   : current floor from the floor controller
//   seletor_andar : target floor to the floor controller
//   porta_aberta  : door open
//   subindo       : travel direction, 1 = up
//   pendentes     : latched, not yet served calls
//   ocupado       : scheduler not idle
module escalonador_chamadas
  import pacote_elevador::*;
#(
  parameter int N_ANDARES = N_ANDARES_DEF,
  parameter int W_ANDAR   = W_ANDAR_DEF,
  parameter int T_PORTA   = 8
) (
  input  logic                 clock_in,
  input  logic                 reset,
  input  logic [N_ANDARES-1:0] botoes,
  input  logic [W_ANDAR-1:0]   andar_atual,
  output logic [W_ANDAR-1:0]   seletor_andar,
  output logic                 porta_aberta,
  output logic                 subindo,
  output logic [N_ANDARES-1:0] pendentes,
  output logic                 ocupado
);

  localparam int W_CONT = (T_PORTA > 1) ? $clog2(T_PORTA) : 1;
  localparam logic [W_CONT-1:0] CONT_INICIAL = W_CONT'(T_PORTA - 1);

  estado_t               estado, estadoProx;
  logic [W_CONT-1:0]     contador, contadorProx;
  logic [N_ANDARES-1:0]  pendentesProx, limpar;
  logic [N_ANDARES-1:0]  mascaraAtual, mascaraAlvo;
  logic [W_ANDAR-1:0]    seletorProx;
  logic                  portaProx, subindoProx;
  logic                  temAcima, temAbaixo, subirScan;
  logic [W_ANDAR-1:0]    proxAcima, proxAbaixo, alvoScan;

  // One-hot views of the current and target floors; an out-of-range floor
  // index decodes to all zeros and therefore never matches a call.
  always_comb begin
    mascaraAtual = '0;
    mascaraAlvo  = '0;
    for (int i = 0; i < N_ANDARES; i++) begin
      mascaraAtual[i] = (andar_atual == W_ANDAR'(i));
      mascaraAlvo[i]  = (seletor_andar == W_ANDAR'(i));
    end
  end

  seletor_alvo #(
    .N_ANDARES(N_ANDARES),
    .W_ANDAR  (W_ANDAR)
  ) uSeletor (
    .pendentes       (pendentes),
    .andar           (andar_atual),
    .subindo         (subindo),
    .tem_acima       (temAcima),
    .tem_abaixo      (temAbaixo),
    .mais_prox_acima (proxAcima),
    .mais_prox_abaixo(proxAbaixo),
    .alvo            (alvoScan),
    .subir           (subirScan)
  );

  always_comb begin
    estadoProx   = estado;
    contadorProx = contador;
    seletorProx  = seletor_andar;
    portaProx    = porta_aberta;
    subindoProx  = subindo;
    limpar       = '0;
    case (estado)
      PARADO: begin
        // A call at the car's own floor, latched or pressed now, opens the
        // door directly and is never left latched.
        if (|((pendentes | botoes) & mascaraAtual)) begin
          estadoProx   = PORTA_ABERTA;
          limpar       = mascaraAtual;
          seletorProx  = andar_atual;
          portaProx    = 1'b1;
          contadorProx = CONT_INICIAL;
        end else if (|pendentes) begin
          seletorProx = alvoScan;
          subindoProx = subirScan;
          estadoProx  = MOVENDO;
        end
      end
      MOVENDO: begin
        if (andar_atual == seletor_andar) begin
          estadoProx   = PORTA_ABERTA;
          limpar       = mascaraAlvo;
          portaProx    = 1'b1;
          contadorProx = CONT_INICIAL;
        end else if (subindo && temAcima && (proxAcima < seletor_andar)) begin
          seletorProx = proxAcima;
        end else if (!subindo && temAbaixo && (proxAbaixo > seletor_andar)) begin
          seletorProx = proxAbaixo;
        end
      end
      PORTA_ABERTA: begin
        // Pressing the floor being served keeps the door open instead of latching.
        limpar = mascaraAlvo;
        if (|(botoes & mascaraAlvo)) begin
          contadorProx = CONT_INICIAL;
        end else if (contador == '0) begin
          portaProx  = 1'b0;
          estadoProx = PARADO;
        end else begin
          contadorProx = contador - 1'b1;
        end
      end
      default: estadoProx = PARADO;
    endcase
    pendentesProx = (pendentes | botoes) & ~limpar;
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      estado        <= PARADO;
      contador      <= '0;
      pendentes     <= '0;
      seletor_andar <= '0;
      porta_aberta  <= 1'b0;
      subindo       <= 1'b1;
    end else begin
      estado        <= estadoProx;
      contador      <= contadorProx;
      pendentes     <= pendentesProx;
      seletor_andar <= seletorProx;
      porta_aberta  <= portaProx;
      subindo       <= subindoProx;
    end
  end

  assign ocupado = (estado != PARADO);

endmodule
